uart_slave: RTL and testbench

UART_SLAVE -- requirements
Module: uart_slave

---
 rtl/uart_slave.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_slave.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_slave.sv
// uart_slave: single-wire half-duplex UART responder.
// Receives a framed word {3'b010, payload, 3'b101} (LSB first after a start bit),
// waits TURN_BITS bit periods, then answers with par_data_in in the same framing.
// Optional power-up presence announce: define UART_SLAVE_ANNOUNCE_EN.
module uart_slave #(
  parameter int NBIT_RX         = 10,
  parameter int NBIT_TX         = 10,
  parameter int BPS_COUNT_NUM   = 48,
  parameter int START_COUNT_NUM = 24,
  parameter int TURN_BITS       = 4,
  parameter int ANNOUNCE_PULSES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [NBIT_TX-1:0] par_data_in,
  output logic [NBIT_RX-1:0] par_data_out,
  output logic               rx_valid,
  output logic               error_flag,
  output logic               busy,
  inout  wire                ser_data
);

  localparam int RXW  = NBIT_RX + 6;
  localparam int TXW  = NBIT_TX + 6;
  localparam int CMAX = (BPS_COUNT_NUM > START_COUNT_NUM) ? BPS_COUNT_NUM : START_COUNT_NUM;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
`ifdef UART_SLAVE_ANNOUNCE_EN
  localparam int AMAX = 2 * ANNOUNCE_PULSES;
`else
  localparam int AMAX = 1;
`endif
  localparam int IM0  = (RXW > TXW) ? RXW : TXW;
  localparam int IM1  = (IM0 > TURN_BITS) ? IM0 : TURN_BITS;
  localparam int IMAX = (IM1 > AMAX) ? IM1 : AMAX;
  localparam int IW   = (IMAX > 1) ? $clog2(IMAX) : 1;

  localparam logic [CW-1:0] BPS_LAST   = CW'(BPS_COUNT_NUM - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_COUNT_NUM - 1);
  localparam logic [IW-1:0] RX_LAST    = IW'(RXW - 1);
  localparam logic [IW-1:0] TX_LAST    = IW'(TXW - 1);
  localparam logic [IW-1:0] TURN_LAST  = IW'(TURN_BITS - 1);

  typedef enum logic [2:0] {
    ANNOUNCE, RX_IDLE, RX_START, RX_DATA, TURN, TX_START, TX_DATA, TX_STOP
  } state_t;

`ifdef UART_SLAVE_ANNOUNCE_EN
  localparam logic [IW-1:0] ANN_LAST  = IW'(2 * ANNOUNCE_PULSES - 1);
  localparam state_t        RST_STATE = ANNOUNCE;
`else
  localparam state_t        RST_STATE = RX_IDLE;
`endif

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  idx;
  logic           s1, s2, s3;
  logic [RXW-1:0] rx_sh;
  logic [RXW-1:0] rx_nxt;
  logic [TXW-1:0] tx_sh;
  logic           drv_en, drv_val;
  logic           bit_done, start_done, frame_ok;

  // Open-drain style release: only drive while transmitting or announcing.
  assign ser_data = drv_en ? drv_val : 1'bz;

  assign bit_done   = tick && (cnt == BPS_LAST);
  assign start_done = tick && (cnt == START_LAST);
  assign rx_nxt     = {s2, rx_sh[RXW-1:1]};
  assign frame_ok   = (rx_nxt[2:0] == 3'b101) && (rx_nxt[RXW-1:RXW-3] == 3'b010);

  // Two-flop synchronizer plus one history flop for falling-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= ser_data;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Main FSM: tick counting, bit sequencing, line drive and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RST_STATE;
      cnt          <= '0;
      idx          <= '0;
      rx_sh        <= '0;
      tx_sh        <= '0;
      drv_en       <= 1'b0;
      drv_val      <= 1'b1;
      par_data_out <= '0;
      rx_valid     <= 1'b0;
      error_flag   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (tick) cnt <= cnt + 1'b1;
      case (state)
`ifdef UART_SLAVE_ANNOUNCE_EN
        ANNOUNCE: begin
          busy <= 1'b1;
          if (!drv_en) begin
            // first cycle out of reset: start the first low phase with a fresh count
            drv_en  <= 1'b1;
            drv_val <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
          end else if (bit_done) begin
            cnt <= '0;
            if (idx == ANN_LAST) begin
              drv_en  <= 1'b0;
              drv_val <= 1'b1;
              idx     <= '0;
              busy    <= 1'b0;
              state   <= RX_IDLE;
            end else begin
              idx     <= idx + 1'b1;
              drv_val <= ~drv_val;
            end
          end
        end
`endif
        RX_IDLE: begin
          cnt  <= '0;
          idx  <= '0;
          busy <= 1'b0;
          if (s3 && !s2) begin
            // a tick on the detecting edge already belongs to RX_START
            cnt   <= CW'(tick);
            busy  <= 1'b1;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (start_done) begin
            cnt <= '0;
            idx <= '0;
            if (!s2) begin
              state <= RX_DATA;
            end else begin
              busy  <= 1'b0;
              state <= RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (bit_done) begin
            cnt   <= '0;
            rx_sh <= rx_nxt;
            if (idx == RX_LAST) begin
              idx <= '0;
              if (frame_ok) begin
                par_data_out <= rx_nxt[NBIT_RX+2:3];
                rx_valid     <= 1'b1;
                error_flag   <= 1'b0;
                state        <= TURN;
              end else begin
                error_flag <= 1'b1;
                busy       <= 1'b0;
                state      <= RX_IDLE;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        TURN: begin
          if (bit_done) begin
            cnt <= '0;
            if (idx == TURN_LAST) begin
              idx     <= '0;
              tx_sh   <= {3'b010, par_data_in, 3'b101};
              drv_en  <= 1'b1;
              drv_val <= 1'b0;
              state   <= TX_START;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        TX_START: begin
          if (bit_done) begin
            cnt     <= '0;
            idx     <= '0;
            drv_val <= tx_sh[0];
            tx_sh   <= tx_sh >> 1;
            state   <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (bit_done) begin
            cnt <= '0;
            if (idx == TX_LAST) begin
              idx     <= '0;
              drv_val <= 1'b1;
              state   <= TX_STOP;
            end else begin
              idx     <= idx + 1'b1;
              drv_val <= tx_sh[0];
              tx_sh   <= tx_sh >> 1;
            end
          end
        end
        TX_STOP: begin
          if (bit_done) begin
            cnt    <= '0;
            drv_en <= 1'b0;
            busy   <= 1'b0;
            state  <= RX_IDLE;
          end
        end
        default: begin
          drv_en <= 1'b0;
          busy   <= 1'b0;
          state  <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_slave.sv
// Directed bench for uart_slave: tick every clk, 48-clk bit period.
module tb_uart_slave;
  localparam int NB  = 10;
  localparam int BPS = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b1;
  logic [NB-1:0] pdi = '0;
  logic [NB-1:0] pdo;
  logic          rxv, err, busy;
  logic          m_low = 1'b0;
  wire           ser_data;

  assign ser_data = m_low ? 1'b0 : 1'bz;
  pullup (ser_data);

  int errors = 0, checks = 0, cyc = 0, rxv_cnt = 0;

  uart_slave dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .par_data_in(pdi),
    .par_data_out(pdo), .rx_valid(rxv), .error_flag(err), .busy(busy),
    .ser_data(ser_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rxv) rxv_cnt <= rxv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // master frame: start bit then 16 bits LSB first, open-drain (only pulls low)
  task automatic send_frame(input logic [15:0] w, output int p0);
    @(negedge clk);
    p0 = cyc;
    m_low = 1'b1;
    clks(BPS);
    for (int i = 0; i < 16; i++) begin
      m_low = ~w[i];
      clks(BPS);
    end
    m_low = 1'b0;
  endtask

  // wait (bounded) for the response start bit, then sample start, 16 bits, stop
  task automatic get_resp(input int p0, output logic [17:0] r, output int lat);
    bit seen = 0;
    r = '1;
    lat = -1;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (ser_data === 1'b0) seen = 1;
    end
    if (seen) begin
      lat = cyc - p0;
      clks(BPS / 2);
      r[0] = ser_data;
      for (int i = 1; i < 18; i++) begin
        clks(BPS);
        r[i] = ser_data;
      end
    end
  endtask

  // watch the line: count falling edges, shortest/longest low run, busy seen
  task automatic watch(input int n, output int falls, output int minlo, output int maxlo,
                       output int bseen);
    logic prev = 1'b1;
    int run = 0;
    falls = 0; minlo = 9999; maxlo = 0; bseen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy) bseen = 1;
      if (ser_data === 1'b0) begin
        if (prev) falls++;
        run++;
      end else if (!prev) begin
        if (run < minlo) minlo = run;
        if (run > maxlo) maxlo = run;
        run = 0;
      end
      prev = (ser_data === 1'b0) ? 1'b0 : 1'b1;
    end
  endtask

  // full good-frame exchange with checks
  task automatic good_exchange(input string tag, input logic [NB-1:0] pay,
                               input logic [NB-1:0] resp);
    int p0, lat, c0;
    logic [17:0] r;
    pdi = resp;
    c0 = rxv_cnt;
    send_frame({3'b010, pay, 3'b101}, p0);
    get_resp(p0, r, lat);
    // start edge + 3 (sync/detect) + 23 + 16*48 samples + 4*48 turnaround
    chk({tag, " resp latency"}, lat, 986);
    chk({tag, " resp word"}, r, {1'b1, 3'b010, resp, 3'b101, 1'b0});
    chk({tag, " rx data"}, pdo, pay);
    chk({tag, " rx_valid pulses"}, rxv_cnt - c0, 1);
    chk({tag, " error_flag"}, err, 0);
    clks(40);
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " line released"}, ser_data, 1);
  endtask

  int falls, minlo, maxlo, bseen, p0, lat, c0;
  logic [17:0] r;

  initial begin
    // reset state
    clks(3);
    chk("reset pdo", pdo, 0);
    chk("reset rx_valid", rxv, 0);
    chk("reset error", err, 0);
    chk("reset busy", busy, 0);
    chk("reset line", ser_data, 1);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef UART_SLAVE_ANNOUNCE_EN
    watch(16 * BPS + 40, falls, minlo, maxlo, bseen);
    chk("announce falls", falls, 8);
    chk("announce min low", minlo, BPS);
    chk("announce max low", maxlo, BPS);
    chk("announce busy", bseen, 1);
    chk("announce end busy", busy, 0);
`else
    watch(20 * BPS, falls, minlo, maxlo, bseen);
    chk("quiet falls", falls, 0);
    chk("quiet busy", bseen, 0);
`endif
    chk("post-reset line", ser_data, 1);

    // good frame
    good_exchange("frame1", 10'h2A5, 10'h155);

    // bad trailer: rejected, no response, data held
    c0 = rxv_cnt;
    send_frame({3'b010, 10'h0F0, 3'b011}, p0);
    watch(400, falls, minlo, maxlo, bseen);
    chk("bad error_flag", err, 1);
    chk("bad pdo held", pdo, 10'h2A5);
    chk("bad no response", falls, 0);
    chk("bad rx_valid", rxv_cnt - c0, 0);
    chk("bad busy", busy, 0);

    // next good frame clears error
    good_exchange("frame2", 10'h0F0, 10'h3C3);

    // 20-clk glitch on idle line
    c0 = rxv_cnt;
    @(negedge clk);
    m_low = 1'b1;
    clks(10);
    chk("glitch busy mid", busy, 1);
    clks(10);
    m_low = 1'b0;
    clks(100);
    chk("glitch rx_valid", rxv_cnt - c0, 0);
    chk("glitch busy", busy, 0);
    chk("glitch pdo", pdo, 10'h0F0);

    // reset during TX_DATA bit 5 (payload bit 2 = 0 -> line low there)
    pdi = 10'h000;
    send_frame({3'b010, 10'h155, 3'b101}, p0);
    lat = -1;
    for (int i = 0; i < 400 && lat < 0; i++) begin
      @(negedge clk);
      if (ser_data === 1'b0) lat = cyc - p0;
    end
    chk("rst-tx start latency", lat, 986);
    clks(BPS * 6 + 12);
    chk("rst-tx bit5 low", ser_data, 0);
    rst_n = 1'b0;
    #1;
    chk("rst-tx line released", ser_data, 1);
    chk("rst-tx pdo", pdo, 0);
    chk("rst-tx busy", busy, 0);
    chk("rst-tx rx_valid", rxv, 0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef UART_SLAVE_ANNOUNCE_EN
    clks(3);
    chk("announce restart", ser_data, 0);
    clks(16 * BPS + 40);
`else
    watch(10 * BPS, falls, minlo, maxlo, bseen);
    chk("rst-tx quiet", falls, 0);
`endif

    // still works after mid-frame reset
    good_exchange("frame3", 10'h3FF, 10'h2A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
